// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce: per-channel two-flop synchronizer, debounce filter and press/release pulses.
// Optional auto-repeat of key_press when the KEY_AUTOREPEAT_EN macro is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int NKEYS           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_in,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < NKEYS; i++) begin : g_ch
    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             w_diff, w_done, w_rep;

    assign w_diff = sync2_q ^ stable_q;
    assign w_done = w_diff && (cnt_q == C_CNT_LAST);

`ifdef KEY_AUTOREPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [HOLD_W-1:0] C_HOLD_FIRE   = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] C_HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
    logic [HOLD_W-1:0] hold_q, hold_d;

    // Reloading to DELAY-PERIOD makes every later fire land PERIOD cycles apart.
    assign w_rep = !stable_q && !w_done && (hold_q == C_HOLD_FIRE);

    always_comb begin
      hold_d = hold_q + 1'b1;
      if (stable_q || w_done) begin
        hold_d = '0;
      end else if (w_rep) begin
        hold_d = C_HOLD_RELOAD;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
      end else begin
        hold_q <= hold_d;
      end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
    assign w_rep = 1'b0;
`endif

    always_comb begin
      cnt_d     = '0;
      stable_d  = stable_q;
      press_d   = w_rep;
      release_d = 1'b0;
      if (w_done) begin
        stable_d  = sync2_q;
        press_d   = !sync2_q;
        release_d = sync2_q;
      end else if (w_diff) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= 1'b1;
        sync2_q   <= 1'b1;
        stable_q  <= 1'b1;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1_q   <= key_in[i];
        sync2_q   <= sync1_q;
        stable_q  <= stable_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign key_level[i]   = ~stable_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: window-based reference model checked every cycle, plus directed literals.
`default_nettype none

module tb_key_debounce;
  localparam int NK = 3;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int HW = D + 2;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level, key_press, key_release;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  key_debounce #(
    .NKEYS(NK), .DEBOUNCE_CYCLES(D), .CNT_W(3),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a level change is accepted when the last D samples, seen two
  // cycles late through the synchronizer, all agree and differ from the level.
  logic [NK-1:0] hist [HW];
  logic [NK-1:0] m_stable, m_press, m_rel;
  int            hold_t [NK];
  bit            same;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < HW; j++) hist[j] = '1;
      m_stable = '1;
      m_press  = '0;
      m_rel    = '0;
      for (int k = 0; k < NK; k++) hold_t[k] = 0;
    end else begin
      for (int j = HW - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = key_in;
      m_press = '0;
      m_rel   = '0;
      for (int k = 0; k < NK; k++) begin
        same = 1;
        for (int j = 2; j < HW; j++) if (hist[j][k] != hist[2][k]) same = 0;
        if (!m_stable[k]) hold_t[k]++;
        if (same && hist[2][k] != m_stable[k]) begin
          m_stable[k] = hist[2][k];
          if (!hist[2][k]) begin
            m_press[k] = 1'b1;
            hold_t[k]  = 0;
          end else begin
            m_rel[k] = 1'b1;
          end
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (!m_stable[k] && hold_t[k] >= RD && ((hold_t[k] - RD) % RP) == 0) begin
          m_press[k] = 1'b1;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_level",   key_level,   ~m_stable);
      chk("model_press",   key_press,   m_press);
      chk("model_release", key_release, m_rel);
      chk("press_release_excl", key_press & key_release, '0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [8:0]    pat;
  int            npress, at;
  logic [NK-1:0] act;

  initial begin
    rst_n  = 0;
    key_in = '1;
    step(3);
    chk_on = 1;
    chk("reset_level", key_level, '0);
    chk("reset_press", key_press | key_release, '0);
    rst_n = 1;
    step(3);

    // single press and release on channel 0
    key_in[0] = 0;
    step(5); chk("k0_level_early", key_level, 3'b000);
    step(1); chk("k0_press", key_press, 3'b001); chk("k0_level", key_level, 3'b001);
    step(1); chk("k0_press_one", key_press, 3'b000);
    step(4);
    key_in[0] = 1;
    step(5); chk("k0_rel_early", key_release, 3'b000);
    step(1); chk("k0_release", key_release, 3'b001); chk("k0_level_off", key_level, 3'b000);
    step(1); chk("k0_rel_one", key_release, 3'b000);
    step(3);

    // short glitch on channel 1
    key_in[1] = 0;
    step(3);
    key_in[1] = 1;
    act = '0;
    for (int t = 0; t < 12; t++) begin
      step(1);
      act = act | key_level | key_press | key_release;
    end
    chk("k1_glitch_quiet", act, 3'b000);

    // bounce pattern 0,1,0,0,1,0,0,0,0 on channel 2
    pat    = 9'b0_0001_0010;
    npress = 0;
    at     = -1;
    for (int t = 0; t < 16; t++) begin
      key_in[2] = (t < 9) ? pat[t] : 1'b0;
      step(1);
      if (key_press[2]) begin
        npress++;
        at = t;
      end
    end
    chk("k2_bounce_count", NK'(npress), NK'(1));
    chk("k2_bounce_time",  NK'(at),     NK'(10));
    key_in[2] = 1;
    step(10);

    // all channels at once
    key_in = 3'b000;
    step(6); chk("all_press", key_press, 3'b111);
    step(1); chk("all_press_one", key_press, 3'b000);
    step(3);
    key_in = 3'b111;
    step(6); chk("all_release", key_release, 3'b111);
    step(4);

    // reset mid-debounce with key 0 held
    key_in[0] = 0;
    step(4);
    rst_n = 0;
    step(2);
    chk("rst_mid_level", key_level, 3'b000);
    chk("rst_mid_pulse", key_press | key_release, 3'b000);
    rst_n = 1;
    step(5); chk("rst_press_early", key_press, 3'b000);
    step(1); chk("rst_press", key_press, 3'b001);
    step(3);
    key_in[0] = 1;
    step(10);

    // hold behaviour
    key_in[0] = 0;
    step(6); chk("hold_press", key_press, 3'b001);
`ifdef KEY_AUTOREPEAT_EN
    step(9); chk("rep_early", key_press, 3'b000);
    step(1); chk("rep_first", key_press, 3'b001);
    step(3); chk("rep_second", key_press, 3'b001);
    step(11);
    key_in[0] = 1;
    step(6);
    chk("rep_level_off", key_level, 3'b000);
`else
    step(10); chk("norep_10", key_press, 3'b000);
    step(3);  chk("norep_13", key_press, 3'b000);
    step(11);
    key_in[0] = 1;
    step(6);
`endif
    act = '0;
    for (int t = 0; t < 10; t++) begin
      step(1);
      act = act | key_press;
    end
    chk("no_press_after_release", act, 3'b000);

    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter NKEYS, default 3: number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable samples required to accept a level change (20 ms at 50 MHz).
REQ-003 Parameter CNT_W, default 20: width of each debounce counter; SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-004 Parameter REPEAT_DELAY, default 25000000: hold cycles before the first auto-repeat pulse (used only with KEY_AUTOREPEAT_EN).
REQ-005 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses (used only with KEY_AUTOREPEAT_EN).
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 key_in  input  NKEYS  raw push-button levels, active-low (0 = pressed), asynchronous to clk.
REQ-009 key_level  output  NKEYS  debounced level, active-high (1 = pressed), registered.
REQ-010 key_press  output  NKEYS  one-cycle pulse per accepted press (plus repeats when enabled), registered.
REQ-011 key_release  output  NKEYS  one-cycle pulse per accepted release, registered.

Function
REQ-012 Each channel SHALL pass key_in through a two-flop synchronizer before any other logic; synchronizer flops reset to 1.
REQ-013 Each channel SHALL keep a stable register (raw polarity) and a CNT_W-bit counter; counter clears in any cycle where synchronized input equals stable.
REQ-014 While synchronized input differs from stable, counter SHALL increment by 1 per cycle.
REQ-015 In the cycle the counter equals DEBOUNCE_CYCLES-1 and input still differs, stable SHALL load the synchronized value and counter SHALL clear.
REQ-016 key_level SHALL equal the inverted stable register; latency raw edge to key_level = 2 + DEBOUNCE_CYCLES cycles.
REQ-017 key_press SHALL be 1 for exactly the cycle in which key_level goes 0->1; key_release exactly the cycle it goes 1->0.
REQ-018 A disturbance shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no change on any output, and SHALL restart the count.
REQ-019 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous pulses.
REQ-020 key_press and key_release SHALL never be 1 together on one channel.
REQ-021 Counters SHALL never wrap; the REQ-015 compare bounds them.

Reset
REQ-022 While rst_n = 0: synchronizers and stable = 1, counters = 0, key_level = 0, key_press = 0, key_release = 0, repeat state cleared.
REQ-023 Reset mid-debounce or mid-hold SHALL discard progress; a key held through reset release SHALL be re-debounced and yield one key_press after 2 + DEBOUNCE_CYCLES cycles.

Configuration
REQ-024 Macro KEY_AUTOREPEAT_EN defined: per-channel hold counter runs while key_level = 1; extra key_press pulse REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles until release; release clears the hold counter immediately.
REQ-025 KEY_AUTOREPEAT_EN undefined: no hold counter is built; exactly one key_press per accepted press; REQ-004/REQ-005 ignored.

Verification (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-026 key_in[0] 1->0 held -> key_level[0] rises and key_press[0] pulses one cycle 6 cycles after the edge; release held -> key_release[0] pulses 6 cycles after the edge.
REQ-027 key_in[1] low for 3 cycles then high -> key_level, key_press, key_release stay 0.
REQ-028 Bounce pattern 0,1,0,0,1,0,0,0,0 on key_in[2] -> single key_press[2], timed from the start of the final 4-sample run.
REQ-029 All three keys pressed same cycle -> key_press = 3'b111 for one cycle, same cycle.
REQ-030 rst_n pulsed low at count 2 while key_in[0] held low -> outputs 0 during reset; one key_press[0] 6 cycles after rst_n rises.
REQ-031 KEY_AUTOREPEAT_EN, key_in[0] held 30 cycles -> key_press[0] at press, +10, +13, +16, ...; none after key_level[0] falls.
